// File: rtl/int_seq_pkg.sv
// int_seq_pkg: shared types and constants for the interrupt/RTI sequencer.
//   seq_state_e : sequencer FSM states (entry path I_*, return path R_*)
//   FLAG_W      : width of the {C,N,Z} condition bundle
//   FLAG_C/N/Z  : bit positions of each condition inside that bundle
package int_seq_pkg;

  localparam int FLAG_W = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    IDLE,
    I_FLUSH,
    I_PUSH_H,
    I_PUSH_L,
    I_PUSH_F,
    I_VEC,
    R_FLUSH,
    R_POP_F,
    R_POP_L,
    R_POP_H,
    R_JUMP
  } seq_state_e;

endpackage

// File: rtl/int_rti_sequencer_edge_latch.sv
// edge_latch: rising-edge detector with a sticky pending flag.
//   clk, rst_n : clock, async active-low reset
//   sig        : level input (int_req)
//   clr        : consume the pending request (entry accepted this cycle)
//   pending    : edge seen and not yet consumed; also high in the edge cycle
//                itself so an idle sequencer can start without an extra cycle
module edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic clr,
  output logic pending
);

  logic sig_q;
  logic pending_q;
  logic rise;

  assign rise    = sig & ~sig_q;
  assign pending = pending_q | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sig_q <= sig;
      // A consuming entry wins over an edge arriving in the same cycle:
      // that edge is the one being consumed.
      if (clr)
        pending_q <= 1'b0;
      else if (rise)
        pending_q <= 1'b1;
    end
  end

endmodule

// File: rtl/int_rti_sequencer.sv
// int_rti_sequencer: sequences interrupt entry (stall, flush, push PC high,
// PC low, flags, load vector) and RTI return (flush, pop flags, PC low, PC
// high, reload PC) over a push/pop req/ack handshake to the memory stage.
//   clk, rst_n        : clock, async active-low reset
//   int_req           : interrupt level, rising edge requests entry
//   rti_dec           : RTI in decode, 1-cycle pulse
//   pc_in, flags_in   : return PC and {C,N,Z}, captured on entry
//   mem_ack, pop_data : memory-stage completion and popped word
//   stall_fetch, flush_fd                    : front-end control
//   push_req, push_data, pop_req             : stack handshake
//   flag_regsel, flag_restore, flagreg_wr    : flag-register restore path
//   pc_load, pc_target, int_ack, busy        : PC redirect and status
// Build option: NESTED_INT_EN turns the in-handler bit into a 4-bit nesting
// counter (entry allowed below 15), otherwise one level only.
//
// state    | meaning
// IDLE     | waiting; RTI beats a pending interrupt
// I_FLUSH  | capture PC/flags, flush fetch/decode
// I_PUSH_H | push PC high word
// I_PUSH_L | push PC low word
// I_PUSH_F | push {0, C, N, Z}
// I_VEC    | load vector, pulse int_ack
// R_FLUSH  | flush fetch/decode
// R_POP_F  | pop flags, restore flag register on ack
// R_POP_L  | pop PC low word
// R_POP_H  | pop PC high word
// R_JUMP   | load restored PC
module int_rti_sequencer
  import int_seq_pkg::*;
#(
  parameter int              DATA_W       = 16,
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] INT_VEC_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_req,
  input  logic              rti_dec,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] pop_data,
  output logic              stall_fetch,
  output logic              flush_fd,
  output logic              push_req,
  output logic [DATA_W-1:0] push_data,
  output logic              pop_req,
  output logic              flag_regsel,
  output logic [FLAG_W-1:0] flag_restore,
  output logic              flagreg_wr,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              int_ack,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_save;
  logic [FLAG_W-1:0] flags_save;
  logic              pending;
  logic              pend_clr;
  logic              entry_ok;

`ifdef NESTED_INT_EN
  logic [3:0] nest_cnt;
  assign entry_ok = (nest_cnt != 4'hF);
`else
  logic in_handler;
  assign entry_ok = !in_handler;
`endif

  edge_latch u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig     (int_req),
    .clr     (pend_clr),
    .pending (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    stall_fetch  = (state_q != IDLE);
    busy         = (state_q != IDLE);
    flush_fd     = 1'b0;
    push_req     = 1'b0;
    push_data    = '0;
    pop_req      = 1'b0;
    flag_regsel  = 1'b0;
    flag_restore = '0;
    flagreg_wr   = 1'b0;
    pc_load      = 1'b0;
    pc_target    = INT_VEC_ADDR;
    int_ack      = 1'b0;
    pend_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rti_dec) begin
          state_d = R_FLUSH;
        end else if (pending && entry_ok) begin
          state_d  = I_FLUSH;
          pend_clr = 1'b1;
        end
      end
      I_FLUSH: begin
        flush_fd = 1'b1;
        state_d  = I_PUSH_H;
      end
      I_PUSH_H: begin
        push_req  = 1'b1;
        push_data = pc_save[PC_W-1:DATA_W];
        if (mem_ack) state_d = I_PUSH_L;
      end
      I_PUSH_L: begin
        push_req  = 1'b1;
        push_data = pc_save[DATA_W-1:0];
        if (mem_ack) state_d = I_PUSH_F;
      end
      I_PUSH_F: begin
        push_req  = 1'b1;
        push_data = {{(DATA_W-FLAG_W){1'b0}}, flags_save};
        if (mem_ack) state_d = I_VEC;
      end
      I_VEC: begin
        pc_load = 1'b1;
        int_ack = 1'b1;
        state_d = IDLE;
      end
      R_FLUSH: begin
        flush_fd = 1'b1;
        state_d  = R_POP_F;
      end
      R_POP_F: begin
        pop_req = 1'b1;
        if (mem_ack) begin
          flag_regsel  = 1'b1;
          flagreg_wr   = 1'b1;
          flag_restore = {pop_data[FLAG_C], pop_data[FLAG_N], pop_data[FLAG_Z]};
          state_d      = R_POP_L;
        end
      end
      R_POP_L: begin
        pop_req = 1'b1;
        if (mem_ack) state_d = R_POP_H;
      end
      R_POP_H: begin
        pop_req = 1'b1;
        if (mem_ack) state_d = R_JUMP;
      end
      R_JUMP: begin
        pc_load   = 1'b1;
        pc_target = pc_save;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_save    <= '0;
      flags_save <= '0;
    end else begin
      if (pend_clr) begin
        pc_save    <= pc_in;
        flags_save <= flags_in;
      end
      if (state_q == R_POP_L && mem_ack) pc_save[DATA_W-1:0]    <= pop_data;
      if (state_q == R_POP_H && mem_ack) pc_save[PC_W-1:DATA_W] <= pop_data;
    end
  end

`ifdef NESTED_INT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nest_cnt <= 4'd0;
    end else if (state_q == I_VEC && nest_cnt != 4'hF) begin
      nest_cnt <= nest_cnt + 4'd1;
    end else if (state_q == R_JUMP && nest_cnt != 4'd0) begin
      nest_cnt <= nest_cnt - 4'd1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 in_handler <= 1'b0;
    else if (state_q == I_VEC)  in_handler <= 1'b1;
    else if (state_q == R_JUMP) in_handler <= 1'b0;
  end
`endif

endmodule
